// File: rtl/tdm_pkg.sv
// Shared types and sizes for the 4-channel TDM demultiplexer.
// Imported by the slot counter and the top level.
package tdm_pkg;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } tdm_state_t;

  localparam int NUM_CH = 4;
  localparam int SLOT_W = 2;

endpackage

// File: rtl/tdm_slot_ctr.sv
// 2-bit slot position counter for the TDM demultiplexer.
// load0 wins over load1, which wins over inc.
module tdm_slot_ctr
  import tdm_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inc,
  input  logic              load0,
  input  logic              load1,
  output logic [SLOT_W-1:0] slot,
  output logic              last
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot <= '0;
    end else if (load0) begin
      slot <= '0;
    end else if (load1) begin
      slot <= SLOT_W'(1);
    end else if (inc) begin
      slot <= slot + SLOT_W'(1);
    end
  end

  assign last = (slot == SLOT_W'(NUM_CH - 1));

endmodule

// File: rtl/tdm_demux4.sv
// Four-channel TDM demultiplexer with frame-sync lock FSM.
// All outputs are registered; one cycle from accepted word to output.
module tdm_demux4
  import tdm_pkg::*;
#(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] din,
  input  logic         din_valid,
  input  logic         frame_sync,
  output logic [W-1:0] d0,
  output logic [W-1:0] d1,
  output logic [W-1:0] d2,
  output logic [W-1:0] d3,
  output logic [3:0]   stb,
  output logic         frame_done,
  output logic         locked,
  output logic         sync_err
);

  tdm_state_t        state;
  tdm_state_t        nxt;
  logic [SLOT_W-1:0] slot;
  logic              last;
  logic              first;
  logic              inc;
  logic              load0;
  logic              load1;
  logic [NUM_CH-1:0] wr;
  logic              done;
  logic              err;
  logic [W-1:0]      d_q [NUM_CH];

  tdm_slot_ctr u_slot (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (inc),
    .load0 (load0),
    .load1 (load1),
    .slot  (slot),
    .last  (last)
  );

  assign first = (slot == '0);

  always_comb begin
    nxt   = state;
    wr    = '0;
    done  = 1'b0;
    err   = 1'b0;
    inc   = 1'b0;
    load0 = 1'b0;
    load1 = 1'b0;
    if (din_valid) begin
      if (state == HUNT) begin
        if (frame_sync) begin
          wr[0] = 1'b1;
          load1 = 1'b1;
          nxt   = LOCKED;
        end
      end else begin
        unique case (1'b1)
          // Sync anywhere restarts the frame; off slot 0 it is an error.
          frame_sync: begin
            wr[0] = 1'b1;
            load1 = 1'b1;
            err   = !first;
          end
          !frame_sync && first: begin
            err   = 1'b1;
            load0 = 1'b1;
            nxt   = HUNT;
          end
          !frame_sync && !first: begin
            wr[slot] = 1'b1;
            inc      = 1'b1;
            done     = last;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= HUNT;
      stb        <= '0;
      frame_done <= 1'b0;
      sync_err   <= 1'b0;
      locked     <= 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
        d_q[k] <= '0;
      end
    end else begin
      state      <= nxt;
      stb        <= wr;
      frame_done <= done;
      sync_err   <= err;
      locked     <= (nxt == LOCKED);
      for (int k = 0; k < NUM_CH; k++) begin
        if (wr[k]) begin
          d_q[k] <= din;
        end
      end
    end
  end

  assign d0 = d_q[0];
  assign d1 = d_q[1];
  assign d2 = d_q[2];
  assign d3 = d_q[3];

endmodule

// File: tb/tb_tdm_demux4.sv
// Randomized and directed bench for tdm_demux4.
// Outputs are compared each cycle against a frame-level reference model.
module tb_tdm_demux4;

  localparam int W = 8;
  localparam int VW = 4 * W + 7;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] din;
  logic         din_valid;
  logic         frame_sync;
  logic [W-1:0] d0, d1, d2, d3;
  logic [3:0]   stb;
  logic         frame_done;
  logic         locked;
  logic         sync_err;

  int n_pass = 0;
  int n_total = 0;

  // reference model
  bit           m_lock;
  int           m_slot;
  logic [W-1:0] m_d [4];
  logic [3:0]   m_stb;
  bit           m_fd;
  bit           m_err;

  tdm_demux4 #(.W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .din_valid  (din_valid),
    .frame_sync (frame_sync),
    .d0         (d0),
    .d1         (d1),
    .d2         (d2),
    .d3         (d3),
    .stb        (stb),
    .frame_done (frame_done),
    .locked     (locked),
    .sync_err   (sync_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_lock = 0;
    m_slot = 0;
    for (int k = 0; k < 4; k++) m_d[k] = '0;
    m_stb = '0;
    m_fd = 0;
    m_err = 0;
  endtask

  task automatic model_step(input bit v, input bit s, input logic [W-1:0] x);
    m_stb = '0;
    m_fd = 0;
    m_err = 0;
    if (!v) return;
    if (!m_lock) begin
      if (s) begin
        m_d[0] = x; m_stb = 4'b0001; m_slot = 1; m_lock = 1;
      end
    end else if (s) begin
      m_err = (m_slot != 0);
      m_d[0] = x; m_stb = 4'b0001; m_slot = 1;
    end else if (m_slot == 0) begin
      m_err = 1; m_lock = 0;
    end else begin
      m_d[m_slot] = x;
      m_stb = 4'(1 << m_slot);
      m_fd = (m_slot == 3);
      m_slot = (m_slot + 1) % 4;
    end
  endtask

  function automatic logic [VW-1:0] exp_vec();
    return {m_d[0], m_d[1], m_d[2], m_d[3], m_stb, m_fd, m_lock, m_err};
  endfunction

  function automatic logic [VW-1:0] got_vec();
    return {d0, d1, d2, d3, stb, frame_done, locked, sync_err};
  endfunction

  task automatic cyc(input bit v, input bit s, input logic [W-1:0] x);
    din_valid = v;
    frame_sync = s;
    din = x;
    @(posedge clk);
    model_step(v, s, x);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    din_valid = 0;
    frame_sync = 0;
    din = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    n_total++;
    if (got_vec() !== exp_vec())
      $display("FAIL reset got=%h exp=%h", got_vec(), exp_vec());
    else n_pass++;
  endtask

  task automatic test_hunt_drop();
    logic [W-1:0] w [4] = '{8'h1, 8'h0, 8'h1, 8'h1};
    for (int i = 0; i < 4; i++) begin
      cyc(1, 0, w[i]);
      n_total++;
      if (got_vec() !== exp_vec() || stb !== 4'b0 || locked !== 1'b0)
        $display("FAIL hunt_drop[%0d] got=%h exp=%h", i, got_vec(), exp_vec());
      else n_pass++;
    end
  endtask

  task automatic test_frame();
    logic [W-1:0] w [4] = '{8'h1, 8'h0, 8'h1, 8'h1};
    logic [3:0] es [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    for (int i = 0; i < 4; i++) begin
      cyc(1, i == 0, w[i]);
      n_total++;
      if (got_vec() !== exp_vec() || stb !== es[i] || locked !== 1'b1
          || frame_done !== (i == 3))
        $display("FAIL frame[%0d] got=%h exp=%h", i, got_vec(), exp_vec());
      else n_pass++;
    end
  endtask

  task automatic test_gaps();
    int fds = 0;
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 4; i++) begin
        cyc(1, i == 0, W'($urandom));
        fds += int'(frame_done);
        n_total++;
        if (got_vec() !== exp_vec())
          $display("FAIL gaps_word[%0d.%0d] got=%h exp=%h", f, i, got_vec(), exp_vec());
        else n_pass++;
        for (int g = 0; g < 2; g++) begin
          cyc(0, $urandom_range(0, 1), W'($urandom));
          n_total++;
          if (got_vec() !== exp_vec() || stb !== 4'b0)
            $display("FAIL gaps_idle[%0d.%0d] got=%h exp=%h", f, i, got_vec(), exp_vec());
          else n_pass++;
        end
      end
    end
    n_total++;
    if (fds !== 2) $display("FAIL gaps_frame_done got=%0d exp=2", fds);
    else n_pass++;
  endtask

  task automatic test_missing_sync();
    for (int i = 0; i < 4; i++) cyc(1, i == 0, W'(i + 8'h10));
    cyc(1, 0, 8'hAA);
    n_total++;
    if (got_vec() !== exp_vec() || sync_err !== 1'b1 || locked !== 1'b0
        || stb !== 4'b0)
      $display("FAIL missing_sync got=%h exp=%h", got_vec(), exp_vec());
    else n_pass++;
    cyc(1, 1, 8'h5C);
    n_total++;
    if (got_vec() !== exp_vec() || d0 !== 8'h5C || locked !== 1'b1
        || stb !== 4'b0001 || sync_err !== 1'b0)
      $display("FAIL relock got=%h exp=%h", got_vec(), exp_vec());
    else n_pass++;
  endtask

  task automatic test_early_sync();
    cyc(1, 0, 8'h21);
    cyc(1, 1, 8'h01);
    n_total++;
    if (got_vec() !== exp_vec() || sync_err !== 1'b1 || d0 !== 8'h01
        || stb !== 4'b0001 || locked !== 1'b1 || frame_done !== 1'b0)
      $display("FAIL early_sync got=%h exp=%h", got_vec(), exp_vec());
    else n_pass++;
    for (int i = 1; i < 4; i++) begin
      cyc(1, 0, W'(8'h30 + i));
      n_total++;
      if (got_vec() !== exp_vec())
        $display("FAIL early_sync_after[%0d] got=%h exp=%h", i, got_vec(), exp_vec());
      else n_pass++;
    end
  endtask

  task automatic test_async_reset();
    cyc(1, 1, 8'hF0);
    cyc(1, 0, 8'hF1);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    n_total++;
    if (got_vec() !== exp_vec())
      $display("FAIL async_reset got=%h exp=%h", got_vec(), exp_vec());
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, W'($urandom));
      n_total++;
      if (got_vec() !== exp_vec() || locked !== 1'b0 || stb !== 4'b0)
        $display("FAIL post_reset_drop[%0d] got=%h exp=%h", i, got_vec(), exp_vec());
      else n_pass++;
    end
  endtask

  task automatic test_random();
    bit v, s;
    int p;
    for (int i = 0; i < 400; i++) begin
      v = ($urandom_range(0, 9) < 7);
      if (!m_lock) p = 30;
      else if (m_slot == 0) p = 90;
      else p = 5;
      s = ($urandom_range(0, 99) < p);
      cyc(v, s, W'($urandom));
      n_total++;
      if (got_vec() !== exp_vec() || $countones(stb) > 1)
        $display("FAIL random[%0d] got=%h exp=%h", i, got_vec(), exp_vec());
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_hunt_drop();
    test_frame();
    test_gaps();
    test_missing_sync();
    test_early_sync();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
